// File: rtl/ps2_pkg.sv
// Shared command/response codes, state encoding and frame helper for the PS/2 mouse path.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_RST = 4'd1,
    WTX_RST  = 4'd2,
    WACK_RST = 4'd3,
    WBAT     = 4'd4,
    WID      = 4'd5,
    SEND_EN  = 4'd6,
    WTX_EN   = 4'd7,
    WACK_EN  = 4'd8,
    STREAM   = 4'd9,
    FAIL     = 4'd10
  } ps2_state_e;

  // {odd_parity, byte} as expected by the host-to-device sender
  function automatic logic [8:0] tx_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_packet_assembler.sv
// Collects 3-byte stream-mode packets into button/movement registers; active only while enabled.
module ps2_packet_assembler
  import ps2_pkg::*;
#(
  parameter int unsigned PKT_GAP_CYC = 100_000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       pkt_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy
);

  localparam int unsigned GW = $clog2(PKT_GAP_CYC + 1);

  logic [1:0]    idx;
  logic [4:0]    hdr;   // {y_sign, x_sign, buttons} of byte 0
  logic [7:0]    b1;
  logic [GW-1:0] gap;

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      hdr       <= '0;
      b1        <= '0;
      gap       <= '0;
      pkt_valid <= 1'b0;
      buttons   <= '0;
      dx        <= '0;
      dy        <= '0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en) begin
        idx <= '0;
        gap <= '0;
      end else if (rx_valid) begin
        gap <= '0;
        unique case (idx)
          2'd0: begin
            // bit 3 is always set in a header byte; anything else is a sync slip
            if (rx_byte[3]) begin
              hdr <= {rx_byte[5:4], rx_byte[2:0]};
              idx <= 2'd1;
            end
          end
          2'd1: begin
            b1  <= rx_byte;
            idx <= 2'd2;
          end
          default: begin
            buttons   <= hdr[2:0];
            dx        <= {hdr[3], b1};
            dy        <= {hdr[4], rx_byte};
            pkt_valid <= 1'b1;
            idx       <= '0;
          end
        endcase
      end else if (idx != 2'd0) begin
        if (gap == GW'(PKT_GAP_CYC - 1)) begin
          idx <= '0;
          gap <= '0;
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer (reset, BAT/ID, enable reporting) with retry/timeout,
// followed by stream-mode packet assembly.
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 25_000_000,
  parameter int unsigned PKT_GAP_CYC = 100_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       start,
  output logic       tx_send,
  output logic [8:0] tx_data,
  input  logic       tx_ok,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       ready,
  output logic       fail,
  output logic [3:0] state,
  output logic       pkt_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  ps2_state_e    cur, nxt;
  logic          start_q, start_edge;
  logic [TW-1:0] tmo;
  logic [RW-1:0] retry, retry_inc;
  logic          waiting, timeout, adv, err;

  assign start_edge = start & ~start_q;
  assign waiting    = cur inside {WTX_RST, WACK_RST, WBAT, WID, WTX_EN, WACK_EN};
  assign timeout    = (tmo == TW'(TIMEOUT_CYC - 1));
  assign retry_inc  = retry + 1'b1;

  // adv/err split: a valid response always outranks a coincident timeout
  always_comb begin
    adv = 1'b0;
    err = 1'b0;
    nxt = cur;
    unique case (cur)
      SEND_RST: begin adv = 1'b1; nxt = WTX_RST; end
      SEND_EN:  begin adv = 1'b1; nxt = WTX_EN;  end
      WTX_RST, WTX_EN: begin
        adv = tx_ok;
        nxt = (cur == WTX_RST) ? WACK_RST : WACK_EN;
        err = ~tx_ok & (tx_err | timeout);
      end
      WACK_RST, WBAT, WID, WACK_EN: begin
        unique case (cur)
          WACK_RST: begin nxt = WBAT;    adv = (rx_byte == RSP_ACK); end
          WBAT:     begin nxt = WID;     adv = (rx_byte == RSP_BAT); end
          WID:      begin nxt = SEND_EN; adv = (rx_byte == RSP_ID);  end
          default:  begin nxt = STREAM;  adv = (rx_byte == RSP_ACK); end
        endcase
        adv = adv & rx_valid;
        err = rx_valid ? ~adv : timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      cur     <= IDLE;
      start_q <= 1'b0;
      tmo     <= '0;
      retry   <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      start_q <= start;
      tx_send <= 1'b0;
      tmo     <= waiting ? tmo + 1'b1 : '0;
      if (start_edge) begin
        cur   <= SEND_RST;
        retry <= '0;
        tmo   <= '0;
      end else if (adv) begin
        cur <= nxt;
        tmo <= '0;
        if (cur == SEND_RST || cur == SEND_EN) begin
          tx_send <= 1'b1;
          tx_data <= tx_frame((cur == SEND_RST) ? CMD_RESET : CMD_ENABLE);
        end
      end else if (err) begin
        tmo   <= '0;
        retry <= retry_inc;
        cur   <= (retry_inc == RW'(MAX_RETRY)) ? FAIL : SEND_RST;
      end
    end
  end

  assign state = cur;
  assign ready = (cur == STREAM);
  assign fail  = (cur == FAIL);

  ps2_packet_assembler #(
    .PKT_GAP_CYC (PKT_GAP_CYC)
  ) u_pkt (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .en        ((cur == STREAM) & ~start_edge),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .pkt_valid (pkt_valid),
    .buttons   (buttons),
    .dx        (dx),
    .dy        (dy)
  );

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: init sequence, packets, resync, gap, retry, timeout, reset.
module tb_ps2_mouse_init_ctrl;

  localparam int unsigned TMO = 1000;
  localparam int unsigned GAP = 50;

  logic       qzt_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tx_ok = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_send, ready, fail, pkt_valid;
  logic [8:0] tx_data, dx, dy;
  logic [3:0] state;
  logic [2:0] buttons;

  int unsigned n_chk = 0, n_pass = 0, n_send = 0, n_pkt = 0;
  int unsigned send_base, pkt_base;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC (TMO),
    .PKT_GAP_CYC (GAP),
    .MAX_RETRY   (3)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .start     (start),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_ok     (tx_ok),
    .tx_err    (tx_err),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .ready     (ready),
    .fail      (fail),
    .state     (state),
    .pkt_valid (pkt_valid),
    .buttons   (buttons),
    .dx        (dx),
    .dy        (dy)
  );

  always #5 qzt_clk = ~qzt_clk;

  always @(negedge qzt_clk) begin
    if (tx_send)   n_send++;
    if (pkt_valid) n_pkt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge qzt_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic give_ok();
    tx_ok = 1'b1;
    step();
    tx_ok = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int unsigned budget);
    int unsigned n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    check_val(tag, state, s);
  endtask

  initial begin
    step(2);
    check_val("rst_ctrl", {tx_send, tx_data, ready, fail, state, pkt_valid}, 32'h0);
    check_val("rst_pkt", {buttons, dx, dy}, 32'h0);
    reset = 1'b0;
    step();

    // nominal init sequence
    send_base = n_send;
    start = 1'b1;
    step();
    check_val("edge_state", state, 4'd1);
    check_val("edge_nosend", tx_send, 1'b0);
    start = 1'b0;
    step();
    check_val("send_rst", tx_send, 1'b1);
    check_val("data_rst", tx_data, 9'h1FF);
    give_ok();
    check_val("wack_rst", state, 4'd3);
    send_byte(8'hFA);
    check_val("wbat", state, 4'd4);
    send_byte(8'hAA);
    check_val("wid", state, 4'd5);
    send_byte(8'h00);
    check_val("send_en_st", state, 4'd6);
    step();
    check_val("send_en", tx_send, 1'b1);
    check_val("data_en", tx_data, 9'h0F4);
    give_ok();
    check_val("wack_en", state, 4'd8);
    send_byte(8'hFA);
    check_val("ready", ready, 1'b1);
    check_val("n_send_nom", n_send - send_base, 2);

    // packets
    send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
    check_val("pkt1_valid", pkt_valid, 1'b1);
    check_val("pkt1_btn", buttons, 3'b001);
    check_val("pkt1_dx", dx, 9'h005);
    check_val("pkt1_dy", dy, 9'h0FB);
    step();
    check_val("pkt1_pulse", pkt_valid, 1'b0);
    check_val("pkt1_hold", dx, 9'h005);
    send_byte(8'h38); send_byte(8'hFE); send_byte(8'h02);
    check_val("pkt2_btn", buttons, 3'b000);
    check_val("pkt2_dx", dx, 9'h1FE);
    check_val("pkt2_dy", dy, 9'h102);

    // resync: a byte without bit 3 is discarded
    step();
    pkt_base = n_pkt;
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
    step();
    check_val("resync_cnt", n_pkt - pkt_base, 1);
    check_val("resync_dx", dx, 9'h001);

    // gap timeout drops the partial packet
    send_byte(8'h08);
    step(GAP + 5);
    send_byte(8'h09); send_byte(8'h02);
    check_val("gap_nopkt", pkt_valid, 1'b0);
    send_byte(8'h03);
    check_val("gap_valid", pkt_valid, 1'b1);
    check_val("gap_btn", buttons, 3'b001);
    check_val("gap_dx", dx, 9'h002);
    check_val("gap_dy", dy, 9'h003);

    // retry: three resend responses lead to FAIL
    send_base = n_send;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_state("retry_wtx", 4'd2, 10);
      give_ok();
      send_byte(8'hFE);
    end
    check_val("fail_state", state, 4'd10);
    check_val("fail_flag", fail, 1'b1);
    step(20);
    check_val("fail_sticky", state, 4'd10);
    check_val("n_send_fail", n_send - send_base, 3);

    // start edge leaves FAIL
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart", state, 4'd1);
    step();
    check_val("restart_wtx", state, 4'd2);
    check_val("restart_nofail", fail, 1'b0);

    // timeout in WACK_RST at cycle TMO after entry
    give_ok();
    check_val("tmo_entry", state, 4'd3);
    step(TMO - 1);
    check_val("tmo_before", state, 4'd3);
    step();
    check_val("tmo_resend", state, 4'd1);

    // asynchronous reset while in WBAT
    step();
    give_ok();
    send_byte(8'hFA);
    check_val("mid_wbat", state, 4'd4);
    @(posedge qzt_clk);
    #3 reset = 1'b1;
    #1;
    check_val("arst_ctrl", {tx_send, tx_data, ready, fail, state, pkt_valid}, 32'h0);
    check_val("arst_pkt", {buttons, dx, dy}, 32'h0);
    step();
    reset = 1'b0;
    send_base = n_send;
    step(20);
    check_val("arst_idle", state, 4'd0);
    check_val("arst_nosend", n_send - send_base, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
# ps2_mouse_init_ctrl

Sequencer for the PS/2 mouse path. It drives the host-to-device sender through the power-up command sequence (reset, self-test, enable reporting) and checks each device response. It then assembles the 3-byte stream-mode packets into button and movement outputs. It sits between the PS/2 sender and receiver on one side and the application logic on the other, and is the only block that issues `send` to the sender.

## Interface
- `TIMEOUT_CYC`, default 25_000_000: response timeout, 500 ms at 50 MHz `qzt_clk`.
- `PKT_GAP_CYC`, default 100_000: inter-byte gap inside one packet, 2 ms.
- `MAX_RETRY`, default 3: number of failed attempts before entering FAIL.
- `qzt_clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  rising edge begins or restarts initialisation.
- `tx_send`  out  1  one-cycle pulse that starts a transmission.
- `tx_data`  out  9  `{odd_parity, byte}`, held stable from the pulse until `tx_ok` or `tx_err`.
- `tx_ok`, `tx_err`  in  1  sender completion flags. Each is a level sampled only while waiting for the sender.
- `rx_valid`  in  1  one-cycle pulse: received byte is valid.
- `rx_byte`  in  8  received byte.
- `ready`  out  1  high in STREAM.
- `fail`  out  1  high in FAIL.
- `state`  out  4  current state code, for debug.
- `pkt_valid`  out  1  one-cycle pulse: a new packet is available.
- `buttons`  out  3  `{mid, right, left}`.
- `dx`, `dy`  out  9  two's-complement movement, `{sign, byte}`.

## Operation
- States: IDLE, SEND_RST, WTX_RST, WACK_RST, WBAT, WID, SEND_EN, WTX_EN, WACK_EN, STREAM, FAIL.
- IDLE: on a rising edge of `start`, clear the retry counter and go to SEND_RST.
- SEND_RST: set `tx_data = {1'b1, 8'hFF}`, pulse `tx_send`, go to WTX_RST. SEND_EN does the same with `{1'b0, 8'hF4}` and goes to WTX_EN. Parity is `~^byte`.
- WTX_*: `tx_ok` advances to WACK_RST or WACK_EN. `tx_err` is an error.
- WACK_*: `rx_byte == 8'hFA` advances. From WACK_RST go to WBAT; from WACK_EN go to STREAM.
- WBAT: `8'hAA` advances to WID.
- WID: `8'h00` advances to SEND_EN.
- Error cases:
  - any other byte in a WACK/WBAT/WID state, including `8'hFE` and `8'hFC`;
  - `tx_err`;
  - timeout counter reaching `TIMEOUT_CYC` in any WTX/WACK/WBAT/WID state.
- On error, increment the retry counter. If the new value equals `MAX_RETRY`, go to FAIL; otherwise go to SEND_RST.
- FAIL is sticky. Only a `start` edge or `reset` leaves it.
- STREAM: byte index `idx` runs 0 to 2.
  - `idx == 0`: accept the byte only if bit 3 is 1; otherwise discard it and keep `idx = 0`.
  - After byte 2: `buttons = b0[2:0]`, `dx = {b0[4], b1}`, `dy = {b0[5], b2}`, and `pkt_valid` pulses.
  - Overflow bits are not reported.
  - If `idx != 0` and the gap counter reaches `PKT_GAP_CYC`, set `idx = 0` and drop the partial packet.
- A `start` edge in any state except IDLE restarts at SEND_RST with the retry counter cleared.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, `idx` 0.
- `start` edge is registered. `tx_send` pulses 2 cycles after the `start` rise: edge detect, then SEND_RST.
- `tx_send` is high for exactly one cycle per command. The controller never issues a second `send` before `tx_ok` or `tx_err`.
- `rx_valid` is ignored in WTX_* and IDLE.
- `start` edge and `rx_valid` in the same cycle: `start` wins and the byte is dropped.
- Timeout and gap counters clear on every state entry and on every accepted byte.
- Timeout and a valid response in the same cycle: the response wins.
- `pkt_valid` rises the cycle after the third `rx_valid`. Packet fields are updated in that same cycle and held until the next packet.
- `reset` mid-transmission returns to IDLE immediately. The sender is not aborted by this block.

## Structure
- Package `ps2_pkg`:
  - command constants `CMD_RESET` 8'hFF and `CMD_ENABLE` 8'hF4;
  - response constants `RSP_ACK` 8'hFA, `RSP_BAT` 8'hAA, `RSP_ID` 8'h00, `RSP_RESEND` 8'hFE;
  - the state encoding.
- Sub-module `ps2_packet_assembler` (STREAM byte indexing, sync check, gap timeout, output registers), enabled only in STREAM.

## Test plan
- Nominal: `start` pulse; model replies `tx_ok`, then FA, AA, 00, then `tx_ok`, FA → `tx_data` 1FF then 0F4, `ready = 1`, 2 `tx_send` pulses total.
- Packet: in STREAM, bytes 09, 05, FB → `pkt_valid` pulse, `buttons = 3'b001`, `dx = +5`, `dy = 9'h0FB` (+251). Bytes 38, FE, 02 → `dx = -2` (9'h1FE), `dy = -254` (9'h102), `buttons = 0`.
- Resync: byte 00 then 08, 01, 01 → the first byte is dropped and exactly one packet is produced, with `dx = 1`.
- Error/retry: model answers FE to reset three times → three SEND_RST passes, then `fail = 1` and no further `tx_send`. A `start` edge then restarts.
- Timeout: with `TIMEOUT_CYC = 1000`, no response after `tx_ok` → resend at cycle 1000 after entering WACK_RST.
- Reset mid-sequence: assert `reset` in WBAT → all outputs 0 asynchronously, state IDLE, and no `tx_send` until the next `start` edge.
